cic_sample_capture: RTL

CIC_SAMPLE_CAPTURE -- requirements
Module: cic_sample_capture

---
 rtl/echip65_pkg.sv | 15 +
 rtl/sample_fifo.sv | 77 +++++++
 rtl/cic_sample_capture.sv | 136 +++++++++++++
 3 files changed

// File: rtl/echip65_pkg.sv
// Shared word widths and constants for the echip65 CIC decimator readout path.
package echip65_pkg;

  localparam int unsigned NUMBITS    = 25;
  localparam int unsigned OUT_WIDTH  = 16;
  localparam int unsigned FIFO_DEPTH = 8;

  // Unsigned CIC output sits at 2^(NUMBITS-2) for a zero input.
  function automatic int unsigned midscale(input int unsigned nb);
    return 32'd1 << (nb - 2);
  endfunction

  localparam int unsigned MIDSCALE = midscale(NUMBITS);

endpackage

// File: rtl/sample_fifo.sv
// Synchronous sample buffer with a registered head-of-queue output and level count.
module sample_fifo #(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         data_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         data_o,
  output logic                     valid_o,
  output logic [$clog2(Depth):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned CntW  = AddrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [Width-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             full, do_push, do_pop;

  always_comb begin
    full     = (count_q == CntW'(Depth));
    do_pop   = pop_i & valid_q;
    // A push into a full buffer is only taken when a pop frees the slot this cycle.
    do_push  = push_i & (~full | do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + AddrW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + AddrW'(1) : rd_ptr_q;
    count_d  = count_q + CntW'(do_push) - CntW'(do_pop);
    valid_d  = (count_d != '0);
    data_d   = data_q;
    if (valid_d) begin
      // When the buffer drains to just the incoming word, it bypasses memory.
      if ((count_q - CntW'(do_pop)) == '0) begin
        data_d = data_i;
      end else begin
        data_d = mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign level_o = count_q;
  assign full_o  = full;
  assign empty_o = ~valid_q;

endmodule

// File: rtl/cic_sample_capture.sv
// Captures the CIC3 word on each decimation edge, converts it to a rounded, saturated
// signed sample, drops warm-up samples and buffers the rest for a ready/valid consumer.
module cic_sample_capture #(
  parameter int unsigned NUMBITS       = echip65_pkg::NUMBITS,
  parameter int unsigned OUT_WIDTH     = echip65_pkg::OUT_WIDTH,
  parameter int unsigned FIFO_DEPTH    = echip65_pkg::FIFO_DEPTH,
  parameter int unsigned DISCARD_COUNT = 3,
  parameter int unsigned CAPTURE_DELAY = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUMBITS-1:0]              cic_in,
  input  logic                            divided_clk,
  input  logic                            enable,
  output logic [OUT_WIDTH-1:0]            out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            overflow,
  input  logic                            clear_ovf
);

  localparam int unsigned Shift = NUMBITS - 1 - OUT_WIDTH;
  localparam int unsigned CalcW = NUMBITS + 1;
  localparam int unsigned DiscW = $clog2(DISCARD_COUNT + 2);

  localparam logic signed [CalcW-1:0] Midscale  = CalcW'(echip65_pkg::midscale(NUMBITS));
  localparam logic signed [CalcW-1:0] RoundBias = CalcW'(1) << (Shift - 1);
  localparam logic signed [CalcW-1:0] SatHi     = CalcW'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [CalcW-1:0] SatLo     = ~SatHi;

  logic                     div_q, div_d;
  logic [CAPTURE_DELAY-1:0] dly_q, dly_d;
  logic [NUMBITS-1:0]       cap_q, cap_d;
  logic                     cap_vld_q, cap_vld_d;
  logic [OUT_WIDTH-1:0]     res_q, res_d;
  logic                     res_vld_q, res_vld_d;
  logic [DiscW-1:0]         disc_q, disc_d;
  logic                     ovf_q, ovf_d;

  logic                     dec_edge, push, pop;
  logic                     fifo_full, fifo_empty;
  logic signed [CalcW-1:0]  diff, rounded, shifted;
  logic [OUT_WIDTH-1:0]     sat;

  // Edge detect and capture-delay line; enable is sampled only in the edge cycle.
  always_comb begin
    div_d    = divided_clk;
    dec_edge = div_q & ~divided_clk;
    dly_d    = dly_q;
    dly_d[0] = dec_edge & enable;
    for (int i = 1; i < int'(CAPTURE_DELAY); i++) begin
      dly_d[i] = dly_q[i-1];
    end
    cap_vld_d = dly_q[CAPTURE_DELAY-1];
    cap_d     = cap_vld_d ? cic_in : cap_q;
  end

  // Offset to signed, round half-up on the discarded LSBs, then clamp.
  always_comb begin
    diff    = $signed({1'b0, cap_q}) - Midscale;
    rounded = diff + RoundBias;
    shifted = rounded >>> Shift;
    if (shifted > SatHi) begin
      sat = SatHi[OUT_WIDTH-1:0];
    end else if (shifted < SatLo) begin
      sat = SatLo[OUT_WIDTH-1:0];
    end else begin
      sat = shifted[OUT_WIDTH-1:0];
    end
    res_d     = cap_vld_q ? sat : res_q;
    res_vld_d = cap_vld_q;
  end

  always_comb begin
    push   = 1'b0;
    disc_d = disc_q;
    if (res_vld_q) begin
      if (disc_q < DiscW'(DISCARD_COUNT)) begin
        disc_d = disc_q + DiscW'(1);
      end else begin
        push = 1'b1;
      end
    end
    pop   = ~fifo_empty & out_ready;
    ovf_d = ovf_q;
    if (clear_ovf) begin
      ovf_d = 1'b0;
    end
    // A drop in the same cycle as a clear must remain visible.
    if (push && fifo_full && !pop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q     <= 1'b0;
      dly_q     <= '0;
      cap_q     <= '0;
      cap_vld_q <= 1'b0;
      res_q     <= '0;
      res_vld_q <= 1'b0;
      disc_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      div_q     <= div_d;
      dly_q     <= dly_d;
      cap_q     <= cap_d;
      cap_vld_q <= cap_vld_d;
      res_q     <= res_d;
      res_vld_q <= res_vld_d;
      disc_q    <= disc_d;
      ovf_q     <= ovf_d;
    end
  end

  sample_fifo #(
    .Width (OUT_WIDTH),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (push),
    .data_i  (res_q),
    .pop_i   (pop),
    .data_o  (out_data),
    .valid_o (out_valid),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign overflow = ovf_q;

endmodule
